mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store initiator that drives the word-wide data memory from the CPU side. Accepts byte, halfword and word load/store requests over a valid/ready handshake. Performs alignment and range checks and sign/zero extension on loads. Sub-word stores use a read-modify-write sequence, because the memory supports only whole-word writes (write_enable, word addr, write_data, combinational read_data).

Parameters:
ADDR_WIDTH, 12, byte-address width of the attached memory; addresses at or above 1<<ADDR_WIDTH fault

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 byte, 1 half, 2 word, 3 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (low byte/half used for sub-word)
resp_valid  output  1  response present
resp_ready  input  1  response consumer ready
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  request rejected; no memory write performed
mem_we  output  1  memory write_enable
mem_addr  output  32  memory address, always word-aligned ({addr[31:2],2'b00})
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- States: IDLE, READ, WRITE, RESP. Registered state; memory-side outputs decoded from state and latched request.
- Reset (synchronous, priority over all): state IDLE, resp_valid 0, resp_rdata 0, resp_fault 0, latched request cleared. mem_we 0, mem_addr 0, mem_wdata 0. Any in-flight request is dropped with no response.
- IDLE: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0. On the edge with req_valid&&req_ready, the unit latches write/size/signed/addr/wdata.
  - If a fault is detected: go to RESP with resp_fault=1 and resp_rdata=0.
  - Otherwise: go to READ.
- Fault conditions (any):
  - size==3
  - size==1 && addr[0]
  - size==2 && addr[1:0]!=0
  - addr[31:ADDR_WIDTH]!=0
- READ (1 cycle): req_ready=0, mem_we=0, mem_addr=word address. At the end edge, mem_rdata is captured into the old-word buffer.
  - Load: compute resp_rdata and go to RESP.
  - Store: go to WRITE.
  - Word stores also pass through READ, so every access has the same shape.
- Load extraction (little-endian lanes):
  - Byte k=addr[1:0] is bits [8k+7:8k].
  - Half: addr[1]=0 gives [15:0], addr[1]=1 gives [31:16].
  - Extension is sign or zero per req_signed.
  - Word loads ignore req_signed.
- WRITE (1 cycle): mem_we=1, mem_addr=word address, mem_wdata = old word with the addressed lane replaced by the low byte/half of wdata (word: wdata unchanged). The write commits at the end edge. Then go to RESP with resp_rdata=0 and resp_fault=0.
- RESP: resp_valid=1; resp_rdata and resp_fault are held stable. req_ready=0. On resp_valid&&resp_ready, go to IDLE and clear resp_valid on the same edge. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Latency, with E0 the accept edge:
  - Load: resp_valid high from E2 (edges E0→READ, E1→RESP).
  - Store: memory written at E2, resp_valid high from E3.
  - Fault: resp_valid high from E1.
- req_* inputs are ignored outside IDLE. The latched copy is used throughout, so request changes mid-operation have no effect.
- Reset asserted during WRITE: mem_we is still 1 for that cycle; the memory's own reset takes precedence, and the unit returns to IDLE.

Test Plan:
- Memory word 0x10 = 0x8899AABB; load byte signed at 0x11 → resp_rdata 0xFFFFFFAA, fault 0, resp_valid exactly 2 cycles after accept; same request unsigned → 0x000000AA.
- Store half 0x1234 at 0x12 over 0x8899AABB → single mem_we pulse with mem_addr 0x10, mem_wdata 0x1234AABB; follow-up word load returns 0x1234AABB.
- Word load at 0x06, half store at 0x03, and size=3 at 0x00 → each gives resp_fault 1, rdata 0, resp_valid 1 cycle after accept, mem_we never asserted.
- With ADDR_WIDTH=12, word store 0xDEADBEEF at 0x1000 → fault 1, no write. At 0xFFC → write succeeds and a reload returns 0xDEADBEEF.
- Hold resp_ready=0 for 5 cycles after a load response → resp_valid, rdata and fault stay stable, and req_ready stays 0 while req_valid=1 with a new request (not accepted). Release → IDLE for one cycle, then the new request is accepted.
- Assert reset in READ of a byte store → no mem_we pulse, no response. Outputs read resp_valid 0, req_ready 1, mem_addr 0 on the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator between the CPU request channel and a word-wide data
// memory that only supports whole-word writes. Byte, halfword and word
// accesses are accepted over a valid/ready handshake. Each request is checked
// for alignment and range. Loads are extracted from their lane and then
// sign- or zero-extended. Sub-word stores are built by read-modify-write.
//
// Every non-faulting access takes the same path, IDLE -> READ (-> WRITE)
// -> RESP, so a word store also performs one read cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; memory port quiet (addr/wdata/we = 0)
// READ  | word address on memory; old word captured at end of cycle
// WRITE | merged word driven with mem_we=1; commits at end of cycle
// RESP  | response held stable until resp_ready
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_size            0 byte, 1 half, 2 word, 3 illegal
//   req_signed          load extension: 1 = sign, 0 = zero
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and faults)
//   resp_fault          request rejected; no memory write was performed
//   mem_we              memory write enable
//   mem_addr            word-aligned memory address
//   mem_wdata           memory write data
//   mem_rdata           combinational memory read data for mem_addr
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] old_word;

    logic        req_fault;
    logic [31:0] word_addr;
    logic [31:0] merged_word;

    // Fault detection on the live request. It is only used on the accept edge.
    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'd3)
            req_fault = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_fault = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if ((req_addr >> ADDR_WIDTH) != 32'd0)
            req_fault = 1'b1;
    end

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'd0;
        h = 16'd0;
        r = word;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the low byte or half
    // of the store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = old;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1])
                    r[31:16] = wdata[15:0];
                else
                    r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    always_comb begin
        word_addr   = {lat_addr[31:2], 2'b00};
        merged_word = merge_store(old_word, lat_wdata, lat_size, lat_addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            lat_write  <= 1'b0;
            lat_size   <= 2'd0;
            lat_signed <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            old_word   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= S_RESP;
                        end else begin
                            state      <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    old_word <= mem_rdata;
                    if (lat_write) begin
                        state <= S_WRITE;
                    end else begin
                        resp_rdata <= extract_load(mem_rdata, lat_size,
                                                   lat_addr[1:0], lat_signed);
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_rdata <= 32'd0;
                    resp_fault <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The memory side is decoded from the registered state. A reset that
    // arrives during WRITE therefore still shows mem_we for that cycle.
    always_comb begin
        req_ready = (state == S_IDLE);
        mem_we    = (state == S_WRITE);
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state == S_READ || state == S_WRITE)
            mem_addr = word_addr;
        if (state == S_WRITE)
            mem_wdata = merged_word;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 4 KiB, combinational read, whole-word write.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];

    int          we_cnt = 0;
    logic [31:0] we_addr = 32'd0;
    logic [31:0] we_data = 32'd0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [3:0]  exp_lat;
        logic [31:0] exp_mwdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // Issue one request with resp_ready high. Measure the number of edges
    // from accept until resp_valid is seen, and return the response.
    task automatic run_req(input vec_t v, output logic [3:0] lat,
                           output logic [31:0] rdata, output logic fault);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = 1'b1;
        lat   = 4'd0;
        rdata = 32'hx;
        fault = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 32'hFFFF_FFFF;
            if (resp_valid) begin
                lat   = c[3:0];
                rdata = resp_rdata;
                fault = resp_fault;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
    endtask

    initial begin
        logic [3:0]  lat;
        logic [31:0] rd;
        logic        ft;
        int          we0;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;

        //            wr    size  sgn   addr          wdata         rdata         flt  lat  mwdata
        vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,        32'hFFFF_FFAA, 1'b0, 4'd2, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_00AA, 1'b0, 4'd2, 32'h0};
        vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFF_8899, 1'b0, 4'd2, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,        32'h0000_0088, 1'b0, 4'd2, 32'h0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_1234, 32'h0,        1'b0, 4'd3, 32'h1234_AABB};
        vecs[5]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0010, 32'h0,        32'h1234_AABB, 1'b0, 4'd2, 32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFF_AABB, 1'b0, 4'd2, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 4'd1, 32'h0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_5555, 32'h0,        1'b1, 4'd1, 32'h0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 4'd1, 32'h0};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        1'b1, 4'd1, 32'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'd3, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'd2, 32'h0};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_0FFD, 32'h0000_005A, 32'h0,        1'b0, 4'd3, 32'hDEAD_5AEF};
        vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0FFE, 32'h0,        32'hFFFF_FFAD, 1'b0, 4'd2, 32'h0};
        vecs[15] = '{1'b1, 2'd0, 1'b1, 32'h0000_0013, 32'hFFFF_FF77, 32'h0,        1'b0, 4'd3, 32'h7734_AABB};
        vecs[16] = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,        32'h0,        1'b1, 4'd1, 32'h0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst.mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst.mem_addr",   mem_addr,  32'd0);
        chk("rst.mem_wdata",  mem_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            we0 = we_cnt;
            run_req(vecs[i], lat, rd, ft);
            chk($sformatf("v%0d.latency", i), {28'd0, lat}, {28'd0, vecs[i].exp_lat});
            chk($sformatf("v%0d.rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d.fault", i), {31'd0, ft}, {31'd0, vecs[i].exp_fault});
            if (vecs[i].wr && !vecs[i].exp_fault) begin
                chk($sformatf("v%0d.we_pulses", i), we_cnt - we0, 32'd1);
                chk($sformatf("v%0d.we_addr", i), we_addr, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d.we_data", i), we_data, vecs[i].exp_mwdata);
            end else begin
                chk($sformatf("v%0d.we_pulses", i), we_cnt - we0, 32'd0);
            end
            @(negedge clk);
            chk($sformatf("v%0d.idle_ready", i), {31'd0, req_ready}, 32'd1);
        end

        // Backpressure: hold the response and present a new request meanwhile.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b1;
        req_addr   = 32'h11;
        @(posedge clk);
        @(negedge clk);
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        @(posedge clk);
        @(negedge clk);
        chk("bp.resp_valid_on", {31'd0, resp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp.hold%0d.valid", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp.hold%0d.rdata", c), resp_rdata, 32'hFFFF_FFAA);
            chk($sformatf("bp.hold%0d.fault", c), {31'd0, resp_fault}, 32'd0);
            chk($sformatf("bp.hold%0d.req_ready", c), {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.idle.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp.idle.req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.accepted.req_ready", {31'd0, req_ready}, 32'd0);
        chk("bp.accepted.mem_addr", mem_addr, 32'h10);
        @(posedge clk);
        @(negedge clk);
        chk("bp.new.valid", {31'd0, resp_valid}, 32'd1);
        chk("bp.new.rdata", resp_rdata, 32'h7734_AABB);
        @(posedge clk);
        @(negedge clk);

        // Reset while a byte store is in READ: nothing is written and no response follows.
        we0 = we_cnt;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'h99;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rr.in_read.mem_addr", mem_addr, 32'h10);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rr.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rr.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rr.mem_addr", mem_addr, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rr.no_resp", {31'd0, resp_valid}, 32'd0);
        chk("rr.we_pulses", we_cnt - we0, 32'd0);
        chk("rr.mem_word", mem[4], 32'h7734_AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
